prog_ctr: RTL and testbench
===========================

// Module: prog_ctr
// PURPOSE
//   Program-counter / fetch sequencer feeding instruction memory; sits downstream of alu.
//   Consumes alu's 'taken' flag plus decoded branch/jump/halt controls.
//   Chooses the next-cycle PC: sequential, absolute target or PC-relative target.
//   Runs a start/done handshake with the top-level bench and counts executed instructions.
// PARAMETERS
//   PC_W       10   width of ProgCtr and Target (instruction memory depth = 2**PC_W)
//   CNT_W      16   width of the executed-instruction counter InstCnt
//   START_ADDR 0    PC loaded on Start
// PORTS
//   Clk       in   1       clock, rising edge
//   Reset     in   1       asynchronous reset, active-high
//   Start     in   1       request a run; sampled in any state
//   Halt      in   1       decoded halt instruction at current PC
//   Branch    in   1       decoded conditional branch at current PC
//   Jump      in   1       decoded unconditional jump at current PC
//   taken     in   1       alu branch-condition result; meaningful only with Branch=1
//   RelEn     in   1       1: Target is a signed PC-relative offset; 0: Target is absolute
//   Target    in   PC_W    branch/jump target or offset
//   ProgCtr   out  PC_W    current instruction address
//   Running   out  1       high while in RUN
//   Done      out  1       high in DONE; held until next Start or Reset
//   InstCnt   out  CNT_W   instructions retired since last Start
// BEHAVIOUR
//   Reset (async, any time, incl. mid-run): state=IDLE, ProgCtr=0, InstCnt=0, Running=0, Done=0.
//   States: IDLE, RUN, DONE. All outputs are registered; Running/Done decode state directly.
//   IDLE: Start=1 -> ProgCtr<=START_ADDR, InstCnt<=0, go RUN next edge. Else hold.
//   RUN, one instruction per cycle, priority per edge:
//     1 Start=1 -> restart: ProgCtr<=START_ADDR, InstCnt<=0, stay RUN.
//     2 Halt=1  -> go DONE; ProgCtr holds; InstCnt+=1 (the halt retires).
//     3 Jump=1, or Branch=1 && taken=1 -> ProgCtr<=next_tgt; InstCnt+=1.
//     4 otherwise -> ProgCtr<=ProgCtr+1; InstCnt+=1.
//   next_tgt = RelEn ? ProgCtr + Target (Target two's complement, PC_W-bit add) : Target.
//   All PC arithmetic is modulo 2**PC_W; wrap-around is silent (e.g. 1023+1 -> 0).
//   Branch=1 with taken=0 falls through to PC+1. taken is ignored when Branch=0.
//   Halt outranks Jump/Branch when asserted together; Jump and Branch together act as a jump.
//   InstCnt saturates at 2**CNT_W-1; it does not wrap.
//   DONE: Done=1, ProgCtr and InstCnt hold, Halt/Branch/Jump ignored.
//     Start=1 -> ProgCtr<=START_ADDR, InstCnt<=0, go RUN (Done drops the same edge).
//   Latency: a control decision at edge n appears on ProgCtr after edge n (1 cycle).
// TESTING
//   T1 Reset mid-RUN at PC=37 -> ProgCtr=0, Done=0, Running=0 immediately, without waiting for a Clk edge.
//   T2 Start pulse, no controls for 5 cycles -> ProgCtr 0,1,2,3,4,5; InstCnt=5.
//   T3 At PC=5: Branch=1, taken=0 -> PC=6; then Branch=1, taken=1, RelEn=0, Target=200 -> PC=200.
//   T4 At PC=200: Jump=1, RelEn=1, Target=10'h3FD (-3) -> PC=197; at PC=1023, no controls -> PC=0.
//   T5 Halt=1 together with Jump=1 at PC=12 -> DONE, ProgCtr stays 12, Done=1 until Start.
//   T6 CNT_W=4: run 20 plain cycles -> InstCnt stops at 15. Start in DONE -> PC=START_ADDR, InstCnt=0.

Source files
------------

// File: rtl/prog_ctr.sv
// prog_ctr: program-counter / fetch sequencer.
// Picks the next instruction address each cycle (sequential, absolute target
// or PC-relative target), runs the start/done handshake with the bench and
// counts retired instructions with a saturating counter.
module prog_ctr #(
  parameter int unsigned     PC_W       = 10,
  parameter int unsigned     CNT_W      = 16,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             Branch,
  input  logic             Jump,
  input  logic             taken,
  input  logic             RelEn,
  input  logic [PC_W-1:0]  Target,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic [CNT_W-1:0] InstCnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             running_q, done_q;

  logic [PC_W-1:0]  pc_seq;
  logic [PC_W-1:0]  pc_tgt;
  logic [CNT_W-1:0] cnt_inc;
  logic             redirect;

  // Address candidates and retire-count increment; all arithmetic wraps
  // modulo the field width, except the counter which sticks at all-ones.
  always_comb begin
    pc_seq   = pc_q + PC_W'(1);
    // A relative Target is two's complement, so a plain PC_W-bit add
    // handles negative offsets and wrap-around at the same time.
    pc_tgt   = RelEn ? (pc_q + Target) : Target;
    // taken is qualified by Branch; Jump alone is unconditional.
    redirect = Jump | (Branch & taken);
    cnt_inc  = (&cnt_q) ? cnt_q : (cnt_q + CNT_W'(1));
  end

  // Next-state, next-PC and next-count selection for the three-state sequencer.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case/if tree can leave one unassigned and infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = START_ADDR;
          cnt_d   = '0;
        end
      end

      ST_RUN: begin
        if (Start) begin
          // Restart wins over anything decoded at the current PC.
          pc_d  = START_ADDR;
          cnt_d = '0;
        end else if (Halt) begin
          // The halt itself retires; PC stays on the halt instruction.
          state_d = ST_DONE;
          cnt_d   = cnt_inc;
        end else if (redirect) begin
          pc_d  = pc_tgt;
          cnt_d = cnt_inc;
        end else begin
          pc_d  = pc_seq;
          cnt_d = cnt_inc;
        end
      end

      ST_DONE: begin
        // Decoded controls are ignored; only Start leaves DONE.
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = START_ADDR;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, PC, counter and status-flag registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      // Status flags are registered copies of the next state, so they line
      // up exactly with state_q without a combinational decode on the output.
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign ProgCtr = pc_q;
  assign InstCnt = cnt_q;
  assign Running = running_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_prog_ctr.sv
// tb_prog_ctr: directed scenarios plus randomized controls against a
// behavioural model. Two instances share the stimulus: the default
// configuration and a small one (CNT_W=4, START_ADDR=100) to exercise
// counter saturation and a non-zero start address.
module tb_prog_ctr;

  localparam int PC_W    = 10;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CNT_W_B = 4;
  localparam int SA_B    = 100;

  logic Clk = 1'b0;
  logic Reset, Start, Halt, Branch, Jump, taken, RelEn;
  logic [PC_W-1:0] Target;

  logic [PC_W-1:0]    pc_a, pc_b;
  logic [15:0]        cnt_a;
  logic [CNT_W_B-1:0] cnt_b;
  logic               run_a, run_b, done_a, done_b;

  prog_ctr #(.PC_W(PC_W), .CNT_W(16), .START_ADDR(10'd0)) dut_a (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Branch(Branch),
    .Jump(Jump), .taken(taken), .RelEn(RelEn), .Target(Target),
    .ProgCtr(pc_a), .Running(run_a), .Done(done_a), .InstCnt(cnt_a)
  );

  prog_ctr #(.PC_W(PC_W), .CNT_W(CNT_W_B), .START_ADDR(10'd100)) dut_b (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Branch(Branch),
    .Jump(Jump), .taken(taken), .RelEn(RelEn), .Target(Target),
    .ProgCtr(pc_b), .Running(run_b), .Done(done_b), .InstCnt(cnt_b)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: mode 0=idle, 1=run, 2=done; plain integer arithmetic.
  int m_mode[2];
  int m_pc[2];
  int m_cnt[2];
  int m_cmax[2] = '{65535, 15};
  int m_sa[2]   = '{0, SA_B};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_pc[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_step();
    int off;
    int tgt;
    off = (int'(Target) >= PC_MOD / 2) ? int'(Target) - PC_MOD : int'(Target);
    for (int i = 0; i < 2; i++) begin
      tgt = RelEn ? (m_pc[i] + off + PC_MOD) % PC_MOD : int'(Target);
      if (Start) begin
        m_mode[i] = 1; m_pc[i] = m_sa[i]; m_cnt[i] = 0;
      end else if (m_mode[i] == 1) begin
        if (m_cnt[i] < m_cmax[i]) m_cnt[i]++;
        if (Halt)                        m_mode[i] = 2;
        else if (Jump || (Branch && taken)) m_pc[i] = tgt;
        else                             m_pc[i] = (m_pc[i] + 1) % PC_MOD;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".a.pc"},   32'(pc_a),   32'(m_pc[0]));
    check({tag, ".a.cnt"},  32'(cnt_a),  32'(m_cnt[0]));
    check({tag, ".a.run"},  32'(run_a),  32'(m_mode[0] == 1));
    check({tag, ".a.done"}, 32'(done_a), 32'(m_mode[0] == 2));
    check({tag, ".b.pc"},   32'(pc_b),   32'(m_pc[1]));
    check({tag, ".b.cnt"},  32'(cnt_b),  32'(m_cnt[1]));
    check({tag, ".b.run"},  32'(run_b),  32'(m_mode[1] == 1));
    check({tag, ".b.done"}, 32'(done_b), 32'(m_mode[1] == 2));
  endtask

  task automatic set_in(input logic s, input logic h, input logic b, input logic j,
                        input logic t, input logic r, input logic [PC_W-1:0] tg);
    Start = s; Halt = h; Branch = b; Jump = j; taken = t; RelEn = r; Target = tg;
  endtask

  // One clock: model consumes the inputs the DUT samples, then compare 1 ns after the edge.
  task automatic tick(input string tag);
    model_step();
    @(posedge Clk);
    #1;
    compare_all(tag);
  endtask

  // Asynchronous reset between edges; checked before any further edge.
  task automatic async_reset(input string tag);
    #1 Reset = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    #1 Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, '0);
    #3;
    model_reset();
    compare_all("reset");
    #9 Reset = 1'b0;

    // Idle holds without Start, even with controls asserted.
    set_in(0, 1, 1, 1, 1, 0, 10'd55);
    tick("idle_hold");

    // T2: start and five plain cycles.
    set_in(1, 0, 0, 0, 0, 0, '0);
    tick("start");
    set_in(0, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) tick("seq");
    check("t2.pc", 32'(pc_a), 32'd5);
    check("t2.cnt", 32'(cnt_a), 32'd5);

    // T3: branch not taken, then taken absolute.
    set_in(0, 0, 1, 0, 0, 0, 10'd200);
    tick("br_nt");
    check("t3.pc_nt", 32'(pc_a), 32'd6);
    set_in(0, 0, 1, 0, 1, 0, 10'd200);
    tick("br_t");
    check("t3.pc_t", 32'(pc_a), 32'd200);

    // T4: relative jump backwards, then wrap from 1023.
    set_in(0, 0, 0, 1, 0, 1, 10'h3FD);
    tick("jrel");
    check("t4.pc_rel", 32'(pc_a), 32'd197);
    set_in(0, 0, 0, 1, 0, 0, 10'd1023);
    tick("j1023");
    set_in(0, 0, 0, 0, 0, 0, '0);
    tick("wrap");
    check("t4.wrap", 32'(pc_a), 32'd0);

    // taken without Branch is ignored; Jump+Branch acts as jump.
    set_in(0, 0, 0, 0, 1, 0, 10'd77);
    tick("taken_only");
    set_in(0, 0, 1, 1, 0, 1, 10'd20);
    tick("jb_both");

    // T5: halt outranks jump at PC=12.
    set_in(0, 0, 0, 1, 0, 0, 10'd12);
    tick("j12");
    set_in(0, 1, 0, 1, 0, 0, 10'd300);
    tick("halt");
    check("t5.pc", 32'(pc_a), 32'd12);
    check("t5.done", 32'(done_a), 32'd1);
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), PC_W'($urandom));
      tick("done_hold");
    end

    // Restart out of DONE, then T6: saturate the 4-bit counter.
    set_in(1, 0, 0, 0, 0, 0, '0);
    tick("restart");
    check("t6.pc_b_start", 32'(pc_b), 32'(SA_B));
    set_in(0, 0, 0, 0, 0, 0, '0);
    for (int i = 0; i < 20; i++) tick("sat");
    check("t6.cnt_sat", 32'(cnt_b), 32'd15);
    set_in(0, 1, 0, 0, 0, 0, '0);
    tick("halt_sat");
    set_in(1, 0, 0, 0, 0, 0, '0);
    tick("restart2");
    check("t6.cnt_clr", 32'(cnt_b), 32'd0);

    // Restart while running.
    set_in(0, 0, 0, 0, 0, 0, '0);
    tick("run");
    set_in(1, 1, 0, 1, 0, 0, 10'd9);
    tick("restart_run");

    // T1: reset mid-run at PC=37.
    set_in(0, 0, 0, 1, 0, 0, 10'd37);
    tick("j37");
    check("t1.pc37", 32'(pc_a), 32'd37);
    async_reset("t1.reset");

    // Randomized controls with occasional start and async reset.
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 24) == 0), ($urandom_range(0, 15) == 0),
             1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
             1'($urandom), PC_W'($urandom));
      tick("rnd");
      if ($urandom_range(0, 99) == 0) async_reset("rnd.reset");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
